// File: rtl/az_sdram_bridge_if.sv
// Bus bundle between the 386SX northbridge RAM port, the SDRAM bridge and the
// Avalon-MM SDRAM controller. The slave modport is the bridge's view.
interface az_sdram_bridge_if;

  logic [21:0] az_addr;
  logic [1:0]  az_be_n;
  logic [15:0] az_data;
  logic        az_rd_n;
  logic        az_wr_n;

  logic [15:0] za_data;
  logic        za_valid;
  logic        za_waitrequest;

  logic [21:0] avm_address;
  logic [1:0]  avm_byteenable;
  logic [15:0] avm_writedata;
  logic        avm_read;
  logic        avm_write;
  logic        avm_waitrequest;
  logic [15:0] avm_readdata;
  logic        avm_readdatavalid;

  modport slave (
    input  az_addr, az_be_n, az_data, az_rd_n, az_wr_n,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid,
    output za_data, za_valid, za_waitrequest,
    output avm_address, avm_byteenable, avm_writedata, avm_read, avm_write
  );

  modport master (
    output az_addr, az_be_n, az_data, az_rd_n, az_wr_n,
    output avm_waitrequest, avm_readdata, avm_readdatavalid,
    input  za_data, za_valid, za_waitrequest,
    input  avm_address, avm_byteenable, avm_writedata, avm_read, avm_write
  );

endinterface

// File: rtl/az_sdram_bridge.sv
// Turns single-cycle northbridge RAM strobes into held Avalon-MM transactions,
// queued in a small command FIFO with at most one read outstanding.
module az_sdram_bridge #(
  parameter int CMD_DEPTH  = 2,
  parameter int RD_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  az_sdram_bridge_if.slave    bus,
  output logic [2:0]          err_flags
);

  localparam int PTR_W   = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 1 + 22 + 2 + 16;

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(CMD_DEPTH);
  localparam logic [15:0]      TMO_LAST   = 16'(RD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD
  } state_t;

  state_t state;
  state_t next_state;

  logic [ENTRY_W-1:0] fifo_mem [CMD_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [15:0]        tmo_cnt;

  logic               rd_strobe;
  logic               wr_strobe;
  logic               one_strobe;
  logic               both_strobes;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               overflow;

  logic [ENTRY_W-1:0] head;
  logic               head_is_write;
  logic [21:0]        head_addr;
  logic [1:0]         head_be;
  logic [15:0]        head_data;

  logic               issue_load;
  logic               pop;
  logic               tmo_clear;
  logic               tmo_inc;
  logic               rd_done;
  logic               rd_tmo;

  assign rd_strobe    = ~bus.az_rd_n;
  assign wr_strobe    = ~bus.az_wr_n;
  assign one_strobe   = rd_strobe ^ wr_strobe;
  assign both_strobes = rd_strobe & wr_strobe;

  // Full is taken from the registered count, so a pop in this same cycle
  // never rescues a strobe that arrives while the FIFO is full.
  assign fifo_full  = (count == FULL_COUNT);
  assign fifo_empty = (count == '0);
  assign push       = one_strobe & ~fifo_full;
  assign overflow   = one_strobe & fifo_full;

  assign bus.za_waitrequest = fifo_full;

  assign head = fifo_mem[rd_ptr];
  assign {head_is_write, head_addr, head_be, head_data} = head;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {wr_strobe, bus.az_addr, ~bus.az_be_n, bus.az_data};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        if (!bus.avm_waitrequest) begin
          next_state = bus.avm_write ? IDLE : WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (bus.avm_readdatavalid || (tmo_cnt == TMO_LAST)) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Readdatavalid takes priority over a timeout landing on the same edge.
  always_comb begin
    issue_load = 1'b0;
    pop        = 1'b0;
    tmo_clear  = 1'b0;
    tmo_inc    = 1'b0;
    rd_done    = 1'b0;
    rd_tmo     = 1'b0;
    case (state)
      IDLE: begin
        issue_load = ~fifo_empty;
      end
      ISSUE: begin
        if (!bus.avm_waitrequest) begin
          pop       = 1'b1;
          tmo_clear = ~bus.avm_write;
        end
      end
      WAIT_RD: begin
        if (bus.avm_readdatavalid) begin
          rd_done = 1'b1;
        end else if (tmo_cnt == TMO_LAST) begin
          rd_tmo = 1'b1;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.avm_address    <= '0;
      bus.avm_byteenable <= '0;
      bus.avm_writedata  <= '0;
      bus.avm_read       <= 1'b0;
      bus.avm_write      <= 1'b0;
    end else if (issue_load) begin
      bus.avm_address    <= head_addr;
      bus.avm_byteenable <= head_be;
      bus.avm_writedata  <= head_data;
      bus.avm_read       <= ~head_is_write;
      bus.avm_write      <= head_is_write;
    end else if (pop) begin
      bus.avm_read       <= 1'b0;
      bus.avm_write      <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if (tmo_clear) begin
      tmo_cnt <= '0;
    end else if (tmo_inc) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  // A timed-out read still completes towards the CPU, with all-ones data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.za_data  <= '0;
      bus.za_valid <= 1'b0;
    end else begin
      bus.za_valid <= rd_done | rd_tmo;
      if (rd_done) begin
        bus.za_data <= bus.avm_readdata;
      end else if (rd_tmo) begin
        bus.za_data <= 16'hFFFF;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_flags <= '0;
    end else begin
      err_flags <= err_flags | {rd_tmo, overflow, both_strobes};
    end
  end

endmodule

// File: tb/tb_az_sdram_bridge.sv
// Directed bench for az_sdram_bridge: reads, stalled writes, overflow,
// read timeout, protocol error and reset during an outstanding read.
module tb_az_sdram_bridge;

  logic       clk;
  logic       reset_n;
  logic [2:0] err_flags;

  int n_checks;
  int n_fail;

  az_sdram_bridge_if bus_if ();

  az_sdram_bridge #(
    .CMD_DEPTH  (2),
    .RD_TIMEOUT (8)
  ) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus_if),
    .err_flags (err_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setIdle();
    bus_if.az_rd_n           = 1'b1;
    bus_if.az_wr_n           = 1'b1;
    bus_if.az_addr           = '0;
    bus_if.az_be_n           = '1;
    bus_if.az_data           = '0;
    bus_if.avm_waitrequest   = 1'b0;
    bus_if.avm_readdata      = '0;
    bus_if.avm_readdatavalid = 1'b0;
  endtask

  task automatic applyReset();
    reset_n = 1'b0;
    setIdle();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // One-cycle strobe; sampled at the next rising edge.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [21:0] addr,
                               input logic [1:0] be_n, input logic [15:0] data);
    bus_if.az_rd_n = ~rd;
    bus_if.az_wr_n = ~wr;
    bus_if.az_addr = addr;
    bus_if.az_be_n = be_n;
    bus_if.az_data = data;
    tick();
    bus_if.az_rd_n = 1'b1;
    bus_if.az_wr_n = 1'b1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_za"}, {bus_if.za_data, bus_if.za_valid, bus_if.za_waitrequest}, 64'h0);
    checkOutput({tag, "_avm"}, {bus_if.avm_read, bus_if.avm_write, bus_if.avm_address,
                                bus_if.avm_byteenable, bus_if.avm_writedata}, 64'h0);
    checkOutput({tag, "_err"}, {61'h0, err_flags}, 64'h0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [21:0] acc_addr [2];
    logic [15:0] acc_data [2];
    int          n_acc;

    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    setIdle();
    tick();
    checkAllZero("reset");
    tick();
    reset_n = 1'b1;
    tick();

    $display("[TB] single read");
    applyReset();
    applyStimulus(1'b1, 1'b0, 22'h12345, 2'b00, 16'h0000);
    checkOutput("rd_not_yet", {63'h0, bus_if.avm_read}, 64'h0);
    tick();
    checkOutput("rd_issue", {bus_if.avm_read, bus_if.avm_write, bus_if.avm_address,
                             bus_if.avm_byteenable}, {38'h0, 1'b1, 1'b0, 22'h12345, 2'b11});
    tick();
    checkOutput("rd_one_cycle", {63'h0, bus_if.avm_read}, 64'h0);
    tick();
    checkOutput("rd_no_early_valid", {63'h0, bus_if.za_valid}, 64'h0);
    bus_if.avm_readdatavalid = 1'b1;
    bus_if.avm_readdata      = 16'hBEEF;
    tick();
    bus_if.avm_readdatavalid = 1'b0;
    bus_if.avm_readdata      = 16'h0000;
    checkOutput("rd_valid", {47'h0, bus_if.za_valid, bus_if.za_data}, {47'h0, 1'b1, 16'hBEEF});
    tick();
    checkOutput("rd_pulse_end", {47'h0, bus_if.za_valid, bus_if.za_data}, {47'h0, 1'b0, 16'hBEEF});
    checkOutput("rd_err", {61'h0, err_flags}, 64'h0);

    $display("[TB] stalled write");
    applyReset();
    bus_if.avm_waitrequest = 1'b1;
    applyStimulus(1'b0, 1'b1, 22'h3ABCD, 2'b10, 16'hA55A);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput($sformatf("wr_hold_%0d", i),
                  {bus_if.avm_write, bus_if.avm_read, bus_if.avm_address, bus_if.avm_byteenable,
                   bus_if.avm_writedata, bus_if.za_valid},
                  {21'h0, 1'b1, 1'b0, 22'h3ABCD, 2'b01, 16'hA55A, 1'b0});
    end
    bus_if.avm_waitrequest = 1'b0;
    tick();
    checkOutput("wr_release", {62'h0, bus_if.avm_write, bus_if.za_valid}, 64'h0);
    tick();
    checkOutput("wr_no_valid", {62'h0, bus_if.avm_write, bus_if.za_valid}, 64'h0);

    $display("[TB] overflow");
    applyReset();
    bus_if.avm_waitrequest = 1'b1;
    applyStimulus(1'b0, 1'b1, 22'h000100, 2'b00, 16'h1111);
    checkOutput("ovf_wait_after1", {63'h0, bus_if.za_waitrequest}, 64'h0);
    applyStimulus(1'b0, 1'b1, 22'h000101, 2'b00, 16'h2222);
    checkOutput("ovf_wait_after2", {63'h0, bus_if.za_waitrequest}, 64'h1);
    applyStimulus(1'b0, 1'b1, 22'h000102, 2'b00, 16'h3333);
    checkOutput("ovf_wait_after3", {63'h0, bus_if.za_waitrequest}, 64'h1);
    checkOutput("ovf_err", {61'h0, err_flags}, 64'h2);
    bus_if.avm_waitrequest = 1'b0;
    n_acc = 0;
    acc_addr[0] = '0; acc_addr[1] = '0;
    acc_data[0] = '0; acc_data[1] = '0;
    for (int i = 0; i < 10; i++) begin
      if (bus_if.avm_write && !bus_if.avm_waitrequest) begin
        if (n_acc < 2) begin
          acc_addr[n_acc] = bus_if.avm_address;
          acc_data[n_acc] = bus_if.avm_writedata;
        end
        n_acc++;
      end
      tick();
    end
    checkOutput("ovf_acc_count", 64'(n_acc), 64'd2);
    checkOutput("ovf_acc0", {26'h0, acc_addr[0], acc_data[0]}, {26'h0, 22'h000100, 16'h1111});
    checkOutput("ovf_acc1", {26'h0, acc_addr[1], acc_data[1]}, {26'h0, 22'h000101, 16'h2222});
    checkOutput("ovf_drained", {63'h0, bus_if.za_waitrequest}, 64'h0);

    $display("[TB] read timeout");
    applyReset();
    applyStimulus(1'b1, 1'b0, 22'h000200, 2'b00, 16'h0000);
    applyStimulus(1'b0, 1'b1, 22'h000201, 2'b01, 16'h5A5A);
    checkOutput("tmo_issue", {41'h0, bus_if.avm_read, bus_if.avm_address}, {41'h0, 1'b1, 22'h000200});
    tick();
    checkOutput("tmo_accepted", {63'h0, bus_if.avm_read}, 64'h0);
    for (int i = 1; i < 8; i++) begin
      tick();
      checkOutput($sformatf("tmo_wait_%0d", i), {62'h0, bus_if.za_valid, bus_if.avm_write}, 64'h0);
    end
    tick();
    checkOutput("tmo_valid", {47'h0, bus_if.za_valid, bus_if.za_data}, {47'h0, 1'b1, 16'hFFFF});
    checkOutput("tmo_err", {61'h0, err_flags}, 64'h4);
    tick();
    checkOutput("tmo_next_write", {40'h0, bus_if.za_valid, bus_if.avm_write, bus_if.avm_address},
                {40'h0, 1'b0, 1'b1, 22'h000201});
    tick();
    checkOutput("tmo_write_done", {61'h0, err_flags}, 64'h4);
    checkOutput("tmo_write_low", {63'h0, bus_if.avm_write}, 64'h0);

    $display("[TB] both strobes");
    applyReset();
    applyStimulus(1'b1, 1'b1, 22'h000300, 2'b00, 16'hCAFE);
    checkOutput("both_err", {61'h0, err_flags}, 64'h1);
    checkOutput("both_wait", {63'h0, bus_if.za_waitrequest}, 64'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("both_quiet_%0d", i), {62'h0, bus_if.avm_read, bus_if.avm_write}, 64'h0);
    end

    $display("[TB] reset mid-read");
    applyReset();
    applyStimulus(1'b1, 1'b0, 22'h000400, 2'b00, 16'h0000);
    tick();
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    checkAllZero("rst_async");
    tick();
    reset_n = 1'b1;
    bus_if.avm_readdatavalid = 1'b1;
    bus_if.avm_readdata      = 16'h1234;
    tick();
    bus_if.avm_readdatavalid = 1'b0;
    bus_if.avm_readdata      = 16'h0000;
    checkOutput("rst_late_rdv", {47'h0, bus_if.za_valid, bus_if.za_data}, 64'h0);
    tick();
    checkAllZero("rst_after");
    tick();
    checkOutput("rst_fifo_empty", {61'h0, bus_if.avm_read, bus_if.avm_write, bus_if.za_waitrequest}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
